// File: rtl/axis_frame_checker.sv
// Receive-side AXI-Stream frame checker: verifies each frame against the incrementing
// test pattern (beat i carries i), counts clean/bad frames and optionally throttles ready.
module axis_frame_checker #(
    parameter int         P_FRAME_LEN    = 16,
    parameter logic [3:0] P_KEEP         = 4'b1111,
    parameter int         P_READY_PERIOD = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_axis_data,
    input  logic [3:0]  i_axis_keep,
    input  logic        i_axis_valid,
    input  logic        i_axis_last,
    output logic        o_axis_ready,
    output logic        o_frame_done,
    output logic        o_frame_ok,
    output logic [31:0] o_ok_cnt,
    output logic [31:0] o_err_cnt,
    output logic        o_err_sticky,
    output logic [15:0] o_beat_idx
);

    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DRAIN} state_t;

    localparam logic [15:0] LAST_IDX = 16'(P_FRAME_LEN - 1);
    localparam logic [15:0] G_LAST   = 16'(P_READY_PERIOD - 1);
    localparam bit          THROTTLE = (P_READY_PERIOD >= 2);

    state_t      state, state_nxt;
    logic [15:0] idx, idx_nxt;
    logic [15:0] g, g_inc;
    logic        run, ready;
    logic        accept, beat_err, close, close_ok;
    logic [31:0] mask;
    logic        data_err, keep_err, len_err;

    assign accept       = i_axis_valid & ready;
    assign o_axis_ready = ready;
    assign o_beat_idx   = idx;

    // Only the last beat may carry partial bytes; earlier beats compare all 32 bits.
    always_comb begin
        mask = '1;
        if (i_axis_last)
            mask = {{8{i_axis_keep[3]}}, {8{i_axis_keep[2]}},
                    {8{i_axis_keep[1]}}, {8{i_axis_keep[0]}}};
    end

    assign data_err = |((i_axis_data ^ {16'h0000, idx}) & mask);
    assign keep_err = i_axis_last ? (i_axis_keep != P_KEEP) : (i_axis_keep != 4'hF);
    assign len_err  = i_axis_last ? (idx != LAST_IDX) : (idx == LAST_IDX);
    assign beat_err = (state != S_DRAIN) && (data_err || keep_err || len_err);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // A bad non-last beat sends the frame to S_DRAIN from either checking state, so
    // the rest of the frame is swallowed unchecked until its last beat.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        close     = 1'b0;
        close_ok  = 1'b0;
        if (accept) begin
            case (state)
                S_IDLE, S_FRAME: begin
                    if (i_axis_last) begin
                        close     = 1'b1;
                        close_ok  = !beat_err;
                        state_nxt = S_IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt   = idx + 16'd1;
                        state_nxt = beat_err ? S_DRAIN : S_FRAME;
                    end
                end
                S_DRAIN: begin
                    if (i_axis_last) begin
                        close     = 1'b1;
                        state_nxt = S_IDLE;
                        idx_nxt   = '0;
                    end else if (idx != 16'hFFFF) begin
                        idx_nxt = idx + 16'd1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_frame_done <= 1'b0;
            o_frame_ok   <= 1'b0;
            o_ok_cnt     <= '0;
            o_err_cnt    <= '0;
            o_err_sticky <= 1'b0;
        end else begin
            o_frame_done <= close;
            o_frame_ok   <= close_ok;
            if (close && close_ok && o_ok_cnt != 32'hFFFF_FFFF)
                o_ok_cnt <= o_ok_cnt + 32'd1;
            if (close && !close_ok) begin
                o_err_sticky <= 1'b1;
                if (o_err_cnt != 32'hFFFF_FFFF)
                    o_err_cnt <= o_err_cnt + 32'd1;
            end
        end
    end

    // Ready phase starts at g = 0 on the first cycle out of reset.
    assign g_inc = (g == G_LAST) ? '0 : g + 16'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            g     <= '0;
            run   <= 1'b0;
            ready <= 1'b0;
        end else begin
            run <= 1'b1;
            if (!THROTTLE) begin
                ready <= 1'b1;
            end else if (!run) begin
                g     <= '0;
                ready <= 1'b1;
            end else begin
                g     <= g_inc;
                ready <= (g_inc != G_LAST);
            end
        end
    end

endmodule

// File: tb/tb_axis_frame_checker.sv
// Randomized bench for axis_frame_checker: two instances (unthrottled / throttled) are
// driven in turn and scored against a frame-level model of the pattern rules.
module tb_axis_frame_checker;

    localparam int         LEN   = 16;
    localparam logic [3:0] KEEP0 = 4'b1000;
    localparam logic [3:0] KEEP1 = 4'b1111;
    localparam int         PER0  = 0;
    localparam int         PER1  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] data  [2];
    logic [3:0]  keep  [2];
    logic        valid [2];
    logic        last  [2];
    logic        ready [2];
    logic        done  [2];
    logic        fok   [2];
    logic [31:0] okc   [2];
    logic [31:0] errc  [2];
    logic        sticky[2];
    logic [15:0] bidx  [2];

    axis_frame_checker #(.P_FRAME_LEN(LEN), .P_KEEP(KEEP0), .P_READY_PERIOD(PER0)) u0 (
        .i_clk(clk), .i_rst(rst), .i_axis_data(data[0]), .i_axis_keep(keep[0]),
        .i_axis_valid(valid[0]), .i_axis_last(last[0]), .o_axis_ready(ready[0]),
        .o_frame_done(done[0]), .o_frame_ok(fok[0]), .o_ok_cnt(okc[0]),
        .o_err_cnt(errc[0]), .o_err_sticky(sticky[0]), .o_beat_idx(bidx[0]));

    axis_frame_checker #(.P_FRAME_LEN(LEN), .P_KEEP(KEEP1), .P_READY_PERIOD(PER1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_axis_data(data[1]), .i_axis_keep(keep[1]),
        .i_axis_valid(valid[1]), .i_axis_last(last[1]), .o_axis_ready(ready[1]),
        .o_frame_done(done[1]), .o_frame_ok(fok[1]), .o_ok_cnt(okc[1]),
        .o_err_cnt(errc[1]), .o_err_sticky(sticky[1]), .o_beat_idx(bidx[1]));

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] last_keep(input int d);
        return (d == 0) ? KEEP0 : KEEP1;
    endfunction

    function automatic int per_of(input int d);
        return (d == 0) ? PER0 : PER1;
    endfunction

    function automatic logic [31:0] expand(input logic [3:0] k);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{k[b]}};
        return m;
    endfunction

    // Frame-level model: a frame is clean iff it has exactly LEN beats and every beat
    // matches its index under the keep rules. Expected close results are queued.
    int cur_n   [2];
    bit cur_bad [2];
    int exp_ok  [2];
    int exp_err [2];
    bit exp_res [2][256];
    int wr      [2];
    int rd      [2];

    task automatic model_beat(input int d, input logic [31:0] dat, input logic [3:0] kp,
                              input logic lst);
        logic [31:0] m;
        logic [3:0]  kx;
        logic [31:0] i;
        i  = 32'(cur_n[d]);
        m  = lst ? expand(kp) : 32'hFFFF_FFFF;
        kx = lst ? last_keep(d) : 4'hF;
        if (kp !== kx || ((dat ^ i) & m) != 0) cur_bad[d] = 1'b1;
        cur_n[d]++;
        if (lst) begin
            bit ok;
            ok = !cur_bad[d] && cur_n[d] == LEN;
            exp_res[d][wr[d] % 256] = ok;
            wr[d]++;
            if (ok) exp_ok[d]++; else exp_err[d]++;
            cur_n[d]   = 0;
            cur_bad[d] = 1'b0;
        end
    endtask

    // Ready phase counter: k = number of clock edges seen with reset low.
    int k = 0;
    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic er;
            int   p;
            p = per_of(d);
            if (k == 0)     er = 1'b0;
            else if (p < 2) er = 1'b1;
            else            er = (((k - 1) % p) != p - 1);
            chk($sformatf("ready%0d", d), 32'(ready[d]), 32'(er));
            if (done[d] === 1'b1) begin
                if (rd[d] == wr[d]) begin
                    chk($sformatf("spurious_done%0d", d), 32'd1, 32'd0);
                end else begin
                    chk($sformatf("frame_ok%0d", d), 32'(fok[d]), 32'(exp_res[d][rd[d] % 256]));
                    rd[d]++;
                end
            end
        end
    end

    task automatic send_beat(input int d, input logic [31:0] dat, input logic [3:0] kp,
                             input logic lst, input int gap);
        bit acc;
        int exp_idx;
        valid[d] = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        valid[d] = 1'b1;
        data[d]  = dat;
        keep[d]  = kp;
        last[d]  = lst;
        acc = 1'b0;
        for (int t = 0; t < 16 && !acc; t++) begin
            @(negedge clk);
            acc = (ready[d] === 1'b1);
            @(posedge clk);
            #1;
        end
        valid[d] = 1'b0;
        if (!acc) begin
            chk($sformatf("hs_timeout%0d", d), 32'd0, 32'd1);
            return;
        end
        model_beat(d, dat, kp, lst);
        exp_idx = lst ? 0 : cur_n[d];
        chk($sformatf("beat_idx%0d", d), 32'(bidx[d]), 32'(exp_idx));
    endtask

    // n beats; optional data replacement at beat c_at and keep override at beat k_at.
    task automatic send_frame(input int d, input int n, input int c_at, input logic [31:0] c_val,
                              input int k_at, input logic [3:0] k_val, input int gapmax);
        for (int i = 0; i < n; i++) begin
            logic        lst;
            logic [3:0]  kp;
            logic [31:0] dat, m;
            lst = (i == n - 1);
            kp  = lst ? last_keep(d) : 4'hF;
            if (i == k_at) kp = k_val;
            m   = lst ? expand(kp) : 32'hFFFF_FFFF;
            dat = (32'(i) & m) | ($urandom() & ~m);
            if (i == c_at) dat = c_val;
            send_beat(d, dat, kp, lst, (gapmax > 0) ? $urandom_range(0, gapmax) : 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) valid[d] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_ready%0d", d),  32'(ready[d]),  32'd0);
            chk($sformatf("rst_done%0d", d),   32'(done[d]),   32'd0);
            chk($sformatf("rst_ok%0d", d),     32'(fok[d]),    32'd0);
            chk($sformatf("rst_okcnt%0d", d),  okc[d],         32'd0);
            chk($sformatf("rst_errcnt%0d", d), errc[d],        32'd0);
            chk($sformatf("rst_sticky%0d", d), 32'(sticky[d]), 32'd0);
            chk($sformatf("rst_idx%0d", d),    32'(bidx[d]),   32'd0);
            cur_n[d] = 0; cur_bad[d] = 1'b0;
            exp_ok[d] = 0; exp_err[d] = 0;
            rd[d] = wr[d];
        end
        rst = 1'b0;
    endtask

    task automatic check_counts(input int d, input string tag);
        repeat (3) begin @(posedge clk); #1; end
        chk($sformatf("%s_ok%0d", tag, d),      okc[d],              32'(exp_ok[d]));
        chk($sformatf("%s_err%0d", tag, d),     errc[d],             32'(exp_err[d]));
        chk($sformatf("%s_sticky%0d", tag, d),  32'(sticky[d]),      32'(exp_err[d] != 0));
        chk($sformatf("%s_pending%0d", tag, d), 32'(wr[d] - rd[d]),  32'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            data[d] = '0; keep[d] = '0; valid[d] = 1'b0; last[d] = 1'b0;
            cur_n[d] = 0; cur_bad[d] = 1'b0; exp_ok[d] = 0; exp_err[d] = 0;
            wr[d] = 0; rd[d] = 0;
        end
        @(posedge clk); #1;

        for (int d = 0; d < 2; d++) begin
            // ten clean back-to-back frames
            do_reset();
            for (int f = 0; f < 10; f++) send_frame(d, LEN, -1, 0, -1, 0, 0);
            check_counts(d, "clean");
            chk($sformatf("clean_ok10_%0d", d), okc[d], 32'd10);

            // beat 5 of frame 2 corrupted
            do_reset();
            for (int f = 0; f < 10; f++)
                send_frame(d, LEN, (f == 2) ? 5 : -1, 32'h0000_0099, -1, 0, 0);
            check_counts(d, "corrupt");
            chk($sformatf("corrupt_err1_%0d", d), errc[d], 32'd1);
            chk($sformatf("corrupt_ok9_%0d", d), okc[d], 32'd9);

            // short, long, then clean frame to show resynchronisation
            do_reset();
            send_frame(d, 8, -1, 0, -1, 0, 0);
            send_frame(d, 21, -1, 0, -1, 0, 0);
            send_frame(d, LEN, -1, 0, -1, 0, 0);
            check_counts(d, "length");
            chk($sformatf("length_err2_%0d", d), errc[d], 32'd2);
            chk($sformatf("length_ok1_%0d", d), okc[d], 32'd1);

            // keep errors on last and non-last beats, single-beat frame
            do_reset();
            send_frame(d, LEN, -1, 0, LEN - 1, 4'b0111, 0);
            send_frame(d, LEN, -1, 0, 3, 4'b1110, 0);
            send_frame(d, 1, -1, 0, -1, 0, 0);
            send_frame(d, LEN, -1, 0, -1, 0, 1);
            check_counts(d, "keep");

            // reset while beat 8 of a frame is presented
            do_reset();
            for (int i = 0; i < 8; i++) send_beat(d, 32'(i), 4'hF, 1'b0, 0);
            valid[d] = 1'b1; data[d] = 32'd8; keep[d] = 4'hF; last[d] = 1'b0;
            do_reset();
            send_frame(d, LEN, -1, 0, -1, 0, 0);
            check_counts(d, "midrst");
            chk($sformatf("midrst_ok1_%0d", d), okc[d], 32'd1);

            // randomized mix with idle gaps
            do_reset();
            for (int f = 0; f < 40; f++) begin
                int kind;
                int n;
                kind = $urandom_range(0, 9);
                n = LEN;
                if (kind == 7) n = $urandom_range(1, 24);
                case (kind)
                    6: send_frame(d, n, $urandom_range(0, LEN - 1),
                                  $urandom() ^ 32'(1 << $urandom_range(0, 31)), -1, 0, 2);
                    8: send_frame(d, n, -1, 0, LEN - 1, 4'($urandom_range(0, 15)), 2);
                    9: send_frame(d, n, -1, 0, $urandom_range(0, LEN - 2),
                                  4'($urandom_range(0, 14)), 2);
                    default: send_frame(d, n, -1, 0, -1, 0, 2);
                endcase
            end
            check_counts(d, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
